// File: rtl/fifo_ptr_pkg.sv
// Shared FIFO pointer-controller defaults.
// Holds the default pointer width and almost-full/almost-empty levels used by channel FIFOs.
package fifo_ptr_pkg;

    localparam int FIFO_PTR_WIDE_DEF = 3;

    // almost_full defaults to this many entries below full
    localparam int AF_MARGIN_DEF = 2;

    localparam int AE_LEVEL_DEF = 2;

    function automatic int fifo_depth(input int ptr_wide);
        return 1 << ptr_wide;
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit pointer register with increment and synchronous clear.
// Ports: clk_i, rst_i (async, high), clr_i, inc_i, ptr_o (W bits, MSB = wrap bit).
module fifo_ptr_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // clear has priority over increment
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer controller: RAM addresses, handshakes, occupancy and status flags.
// Ports: clk, rst, wr_en, rd_en, flush, err_clr in; wr_addr, rd_addr, wr_ack, rd_ack,
// count, full, empty, almost_full, almost_empty, overflow, underflow out.
module fifo_ptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int FIFO_PTR_WIDE = FIFO_PTR_WIDE_DEF,
    parameter int AF_LEVEL      = fifo_depth(FIFO_PTR_WIDE) - AF_MARGIN_DEF,
    parameter int AE_LEVEL      = AE_LEVEL_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic [FIFO_PTR_WIDE-1:0] wr_addr,
    output logic [FIFO_PTR_WIDE-1:0] rd_addr,
    output logic                     wr_ack,
    output logic                     rd_ack,
    output logic [FIFO_PTR_WIDE:0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = FIFO_PTR_WIDE + 1;

    localparam logic [PW-1:0] DEPTH_L = PW'(fifo_depth(FIFO_PTR_WIDE));
    localparam logic [PW-1:0] AF_L    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L    = PW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic ovf_q;
    logic ovf_d;
    logic unf_q;
    logic unf_d;

    // modulo subtraction across the wrap bit yields 0..DEPTH
    assign count = wr_ptr - rd_ptr;

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_L);
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);

    assign wr_ack = wr_en & ~full & ~flush;
    assign rd_ack = rd_en & ~empty & ~flush;

    assign wr_addr = wr_ptr[FIFO_PTR_WIDE-1:0];
    assign rd_addr = rd_ptr[FIFO_PTR_WIDE-1:0];

    fifo_ptr_cnt #(
        .W(PW)
    ) u_wr_ptr (
        .clk_i(clk),
        .rst_i(rst),
        .clr_i(flush),
        .inc_i(wr_ack),
        .ptr_o(wr_ptr)
    );

    fifo_ptr_cnt #(
        .W(PW)
    ) u_rd_ptr (
        .clk_i(clk),
        .rst_i(rst),
        .clr_i(flush),
        .inc_i(rd_ack),
        .ptr_o(rd_ptr)
    );

    // sticky errors: a new error wins over a coincident clear
    always_comb begin
        ovf_d = (wr_en & full & ~flush) | (ovf_q & ~err_clr);
        unf_d = (rd_en & empty & ~flush) | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl (FIFO_PTR_WIDE=3, AF_LEVEL=6, AE_LEVEL=2).
// Driver queues hand-computed per-cycle expectations; a negedge monitor compares them.
module tb_fifo_ptr_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic       flush;
    logic       err_clr;
    logic [2:0] wr_addr;
    logic [2:0] rd_addr;
    logic       wr_ack;
    logic       rd_ack;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    typedef struct packed {
        logic [2:0] wa;
        logic [2:0] ra;
        logic       wk;
        logic       rk;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    fifo_ptr_ctrl #(
        .FIFO_PTR_WIDE(3),
        .AF_LEVEL(6),
        .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .flush(flush),
        .err_clr(err_clr),
        .wr_addr(wr_addr),
        .rd_addr(rd_addr),
        .wr_ack(wr_ack),
        .rd_ack(rd_ack),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic exp_t mk(input int wa, input int ra, input int wk,
                                input int rk, input int cnt, input int ovf,
                                input int unf);
        exp_t e;
        e.wa  = 3'(wa);
        e.ra  = 3'(ra);
        e.wk  = 1'(wk);
        e.rk  = 1'(rk);
        e.cnt = 4'(cnt);
        e.ovf = 1'(ovf);
        e.unf = 1'(unf);
        return e;
    endfunction

    // monitor: outputs are stable mid-cycle, compare at the falling edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            int   c;
            e = sb_q.pop_front();
            c = int'(e.cnt);
            chk("wr_addr", int'(wr_addr), int'(e.wa));
            chk("rd_addr", int'(rd_addr), int'(e.ra));
            chk("wr_ack", int'(wr_ack), int'(e.wk));
            chk("rd_ack", int'(rd_ack), int'(e.rk));
            chk("count", int'(count), c);
            chk("full", int'(full), int'(c == 8));
            chk("empty", int'(empty), int'(c == 0));
            chk("almost_full", int'(almost_full), int'(c >= 6));
            chk("almost_empty", int'(almost_empty), int'(c <= 2));
            chk("overflow", int'(overflow), int'(e.ovf));
            chk("underflow", int'(underflow), int'(e.unf));
        end
    end

    // called at posedge+1: drive one cycle and queue its expected outputs
    task automatic step(input logic w, input logic r, input logic f,
                        input logic ec, input exp_t e);
        wr_en   = w;
        rd_en   = r;
        flush   = f;
        err_clr = ec;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("scoreboard_drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_almost_empty"}, int'(almost_empty), 1);
        chk({tag, "_almost_full"}, int'(almost_full), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_underflow"}, int'(underflow), 0);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
        #2;
        chk_reset("rst_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));

        // fill: addresses 0..7, almost_full from count 6
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, mk(i, 0, 1, 0, i, 0, 0));
        end
        step(0, 0, 0, 0, mk(0, 0, 0, 0, 8, 0, 0));

        // full: read accepted, write rejected, overflow sticky until err_clr
        step(1, 1, 0, 0, mk(0, 0, 0, 1, 8, 0, 0));
        step(0, 0, 0, 0, mk(0, 1, 0, 0, 7, 1, 0));
        step(0, 0, 0, 1, mk(0, 1, 0, 0, 7, 1, 0));
        step(0, 0, 0, 0, mk(0, 1, 0, 0, 7, 0, 0));

        // drain to empty, rd_addr wraps to 0
        for (int i = 1; i < 8; i++) begin
            step(0, 1, 0, 0, mk(0, i, 0, 1, 8 - i, 0, 0));
        end

        // underflow set, clear, then set and clear coinciding
        step(0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
        step(0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
        step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        step(0, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
        step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));

        // empty: write accepted, read rejected, underflow set
        step(1, 1, 0, 0, mk(0, 0, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, mk(1, 0, 0, 0, 1, 0, 1));
        for (int i = 1; i < 4; i++) begin
            step(1, 0, 0, 0, mk(i, 0, 1, 0, i, 0, 1));
        end
        step(0, 0, 0, 0, mk(4, 0, 0, 0, 4, 0, 1));

        // steady state at count 4, both addresses wrap
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0, mk((4 + i) % 8, i % 8, 1, 1, 4, 0, 1));
        end
        step(0, 0, 0, 0, mk(6, 2, 0, 0, 4, 0, 1));

        // count 5, flush overrides write, keeps underflow
        step(1, 0, 0, 0, mk(6, 2, 1, 0, 4, 0, 1));
        step(1, 0, 1, 0, mk(7, 2, 0, 0, 5, 0, 1));
        step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
        step(0, 1, 1, 1, mk(0, 0, 0, 0, 0, 0, 1));

        // count 3 then asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, mk(i, 0, 1, 0, i, 0, 0));
        end
        step(0, 0, 0, 0, mk(3, 0, 0, 0, 3, 0, 0));
        wait_drain();
        rst = 1'b1;
        #1;
        chk_reset("rst_async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, mk(1, 0, 0, 0, 1, 0, 0));
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 Parameter FIFO_PTR_WIDE, default 3, address width; depth DEPTH = 2**FIFO_PTR_WIDE.
REQ-002 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries.
REQ-003 Parameter AE_LEVEL, default 2, almost_empty threshold in entries.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 wr_en  in  1  write request.
REQ-007 rd_en  in  1  read request.
REQ-008 flush  in  1  synchronous pointer clear.
REQ-009 err_clr  in  1  synchronous clear of sticky error flags.
REQ-010 wr_addr  out  FIFO_PTR_WIDE  RAM write address.
REQ-011 rd_addr  out  FIFO_PTR_WIDE  RAM read address.
REQ-012 wr_ack  out  1  write accepted this cycle.
REQ-013 rd_ack  out  1  read accepted this cycle.
REQ-014 count  out  FIFO_PTR_WIDE+1  current occupancy, 0..DEPTH.
REQ-015 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-016 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-017 Internal wr_ptr/rd_ptr SHALL be FIFO_PTR_WIDE+1 bits; the MSB is the wrap bit; wr_addr/rd_addr SHALL be the low FIFO_PTR_WIDE bits.
REQ-018 count SHALL equal wr_ptr - rd_ptr modulo 2**(FIFO_PTR_WIDE+1).
REQ-019 empty SHALL be 1 iff count==0; full SHALL be 1 iff count==DEPTH.
REQ-020 almost_full SHALL be 1 iff count>=AF_LEVEL; almost_empty SHALL be 1 iff count<=AE_LEVEL.
REQ-021 All flags SHALL be combinational from registered pointers; they reflect a write or read in the cycle after its acceptance edge.
REQ-022 wr_ack SHALL equal wr_en & ~full & ~flush; rd_ack SHALL equal rd_en & ~empty & ~flush; both combinational, zero latency.
REQ-023 On an edge with wr_ack, wr_ptr SHALL increment by 1; on an edge with rd_ack, rd_ptr SHALL increment by 1; both may happen in the same cycle.
REQ-024 When full, a simultaneous wr_en and rd_en SHALL accept the read only; the write SHALL be rejected and SHALL set overflow.
REQ-025 When empty, a simultaneous wr_en and rd_en SHALL accept the write only; the read SHALL be rejected and SHALL set underflow.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 in the address bits and SHALL toggle the wrap bit.
REQ-027 overflow SHALL set on any edge with wr_en & full & ~flush; underflow SHALL set on any edge with rd_en & empty & ~flush.
REQ-028 overflow and underflow SHALL hold until err_clr; if set and clear coincide, set SHALL win.
REQ-029 flush SHALL clear both pointers to 0 on the next edge, SHALL override wr_en/rd_en, and SHALL NOT clear the error flags.

Reset
REQ-030 While rst=1: wr_ptr=rd_ptr=0, wr_addr=rd_addr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), overflow=underflow=0.
REQ-031 rst assertion SHALL take effect immediately regardless of clk, including mid-transfer; the first accepted operation occurs on the first rising edge after deassertion.

Structure
REQ-032 Package fifo_ptr_pkg SHALL hold the default FIFO_PTR_WIDE and the AF/AE default constants shared with channel FIFOs.
REQ-033 Sub-module fifo_ptr_cnt (FIFO_PTR_WIDE+1 bit pointer with inc and clr) SHALL be instantiated twice, once for write and once for read.

Verification (FIFO_PTR_WIDE=3, AF_LEVEL=6, AE_LEVEL=2)
REQ-034 Reset, then 8 writes -> wr_addr 0..7 then 0, count=8, full=1, almost_full set from count=6, empty deasserts one cycle after the first write.
REQ-035 Full, assert wr_en+rd_en for one cycle -> rd_ack=1, wr_ack=0, count=7, overflow=1 until err_clr.
REQ-036 Empty, rd_en only -> rd_ack=0, rd_addr unchanged, underflow=1; err_clr pulse -> underflow=0.
REQ-037 count=4, simultaneous wr_en+rd_en over 10 cycles -> count stays 4, both addresses wrap past 7 to 0.
REQ-038 count=5, flush with wr_en=1 -> next cycle count=0, empty=1, wr_addr=rd_addr=0, wr_ack=0, error flags unchanged.
REQ-039 rst asserted between clock edges at count=3 -> outputs take reset values before the next edge.
